morse_char_decoder: RTL

- Downstream of the sequence storage stage. Takes the 160-bit stored message (16 slots × 10-bit symbol codes), walks it oldest-first, and decodes each occupied slot into an 8-bit ASCII character.
- Characters leave over a valid/ready handshake to the display/UART stage.
- Started by a one-cycle start pulse, normally the registered enter event.

---
 rtl/morse_char_decoder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/morse_char_decoder.sv
// Morse character decoder: walks a 16-slot snapshot oldest-first and emits one ASCII char per occupied slot.
// Optional build macro WORD_SPACE_EN: slot code 10'h2FF decodes to an ASCII space instead of ERR_CHAR.
module morse_char_decoder #(
  parameter int          SLOTS    = 16,
  parameter logic [7:0]  ERR_CHAR = 8'h3F
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SLOTS*10-1:0]   seq_in,
  output logic [7:0]            ascii_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            char_count
);

  localparam int IW = $clog2(SLOTS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [SLOTS*10-1:0] snap_q, snap_d;
  logic [7:0]          ascii_q, ascii_d;
  logic                valid_q, valid_d;
  logic [4:0]          count_q, count_d;
  logic [9:0]          slot;
  logic                slot_empty;

  // Symbols are folded into a right-aligned pattern (dot=0, dash=1, first symbol MSB) plus a length.
  function automatic logic [7:0] decode_slot(input logic [9:0] code);
    logic [2:0] len;
    logic [4:0] pat;
    logic       pad_seen;
    logic       bad;
    logic [1:0] sym;
    logic [7:0] ch;
    len      = '0;
    pat      = '0;
    pad_seen = 1'b0;
    bad      = 1'b0;
    for (int unsigned j = 0; j < 5; j++) begin
      sym = code[(9 - 2*j) -: 2];
      if (sym == 2'b10) begin
        bad = 1'b1;
      end else if (sym == 2'b11) begin
        pad_seen = 1'b1;
      end else if (pad_seen) begin
        bad = 1'b1;
      end else begin
        pat = {pat[3:0], sym[0]};
        len = len + 3'd1;
      end
    end
    ch = ERR_CHAR;
    if (!bad) begin
      case ({len, pat})
        {3'd1, 5'b00000}: ch = "E";
        {3'd1, 5'b00001}: ch = "T";
        {3'd2, 5'b00000}: ch = "I";
        {3'd2, 5'b00001}: ch = "A";
        {3'd2, 5'b00010}: ch = "N";
        {3'd2, 5'b00011}: ch = "M";
        {3'd3, 5'b00000}: ch = "S";
        {3'd3, 5'b00001}: ch = "U";
        {3'd3, 5'b00010}: ch = "R";
        {3'd3, 5'b00011}: ch = "W";
        {3'd3, 5'b00100}: ch = "D";
        {3'd3, 5'b00101}: ch = "K";
        {3'd3, 5'b00110}: ch = "G";
        {3'd3, 5'b00111}: ch = "O";
        {3'd4, 5'b00000}: ch = "H";
        {3'd4, 5'b00001}: ch = "V";
        {3'd4, 5'b00010}: ch = "F";
        {3'd4, 5'b00100}: ch = "L";
        {3'd4, 5'b00110}: ch = "P";
        {3'd4, 5'b00111}: ch = "J";
        {3'd4, 5'b01000}: ch = "B";
        {3'd4, 5'b01001}: ch = "X";
        {3'd4, 5'b01010}: ch = "C";
        {3'd4, 5'b01011}: ch = "Y";
        {3'd4, 5'b01100}: ch = "Z";
        {3'd4, 5'b01101}: ch = "Q";
        {3'd5, 5'b11111}: ch = "0";
        {3'd5, 5'b01111}: ch = "1";
        {3'd5, 5'b00111}: ch = "2";
        {3'd5, 5'b00011}: ch = "3";
        {3'd5, 5'b00001}: ch = "4";
        {3'd5, 5'b00000}: ch = "5";
        {3'd5, 5'b10000}: ch = "6";
        {3'd5, 5'b11000}: ch = "7";
        {3'd5, 5'b11100}: ch = "8";
        {3'd5, 5'b11110}: ch = "9";
        default:          ch = ERR_CHAR;
      endcase
    end
`ifdef WORD_SPACE_EN
    if (code == 10'h2FF) ch = 8'h20;
`else
`endif
    return ch;
  endfunction

  always_comb begin
    slot       = snap_q[10*int'(idx_q) +: 10];
    slot_empty = (slot == 10'h3FF);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    ascii_d = ascii_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = seq_in;
          count_d = '0;
          idx_d   = IW'(SLOTS - 1);
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (slot_empty) begin
          if (idx_q == '0) state_d = S_DONE;
          else             idx_d   = idx_q - 1'b1;
        end else begin
          ascii_d = decode_slot(slot);
          valid_d = 1'b1;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          count_d = count_q + 5'd1;
          if (idx_q == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = S_SCAN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= IW'(SLOTS - 1);
      snap_q  <= '1;
      ascii_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      ascii_q <= ascii_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign ascii_out  = ascii_q;
  assign out_valid  = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign char_count = count_q;

endmodule
